// File: rtl/sw_cmd_sched.sv
// Command scheduler and timebase for the BCD hh:mm stopwatch core: button
// conditioning, pending requests, fixed-priority arbitration and state filtering.
module sw_cmd_sched #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_stop,
  input  logic       btn_clr,
  input  logic       btn_load,
  input  logic [2:0] fsm_state,
  output logic       tick,
  output logic       start,
  output logic       lap,
  output logic       stop,
  output logic       clr,
  output logic       load,
  output logic       cmd_drop,
  output logic [7:0] drop_cnt
);

  localparam int unsigned NB    = 5;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
  localparam int unsigned CNT_W = 3;

  // Button bit positions
  localparam int unsigned B_START = 0;
  localparam int unsigned B_LAP   = 1;
  localparam int unsigned B_STOP  = 2;
  localparam int unsigned B_CLR   = 3;
  localparam int unsigned B_LOAD  = 4;

  // Core state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_LAP   = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync1_q, sync1_d;
  logic [NB-1:0]    sync2_q, sync2_d;
  logic [DB_W-1:0]  db_cnt_q [NB];
  logic [DB_W-1:0]  db_cnt_d [NB];
  logic [NB-1:0]    db_lvl_q, db_lvl_d;
  logic [NB-1:0]    db_prev_q, db_prev_d;
  logic [NB-1:0]    pend_q, pend_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q, tick_d;
  logic [NB-1:0]    cmd_q, cmd_d;
  logic             cmd_drop_q, cmd_drop_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [NB-1:0]    rise_c;
  logic [NB-1:0]    sel_c;
  logic [NB-1:0]    legal_c;
  logic [NB-1:0]    issue_c;
  logic [CNT_W-1:0] n_pend_c;
  logic [CNT_W-1:0] n_drop_c;
  logic [8:0]       drop_sum_c;
  logic             pre_last_c;

  assign btn_raw = {btn_load, btn_clr, btn_stop, btn_lap, btn_start};

  // Synchronise, debounce and edge-detect each button
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_lvl_d  = db_lvl_q;
    db_prev_d = db_lvl_q;
    for (int i = 0; i < int'(NB); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_lvl_q[i]) begin
        if (32'(db_cnt_q[i]) + 32'd1 >= DB_CYCLES) begin
          db_lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
    rise_c = db_lvl_q & ~db_prev_q;
  end

  // Fixed-priority selection and legality filtering against the core state
  always_comb begin
    sel_c = '0;
    if      (pend_q[B_CLR])   sel_c[B_CLR]   = 1'b1;
    else if (pend_q[B_STOP])  sel_c[B_STOP]  = 1'b1;
    else if (pend_q[B_LAP])   sel_c[B_LAP]   = 1'b1;
    else if (pend_q[B_START]) sel_c[B_START] = 1'b1;
    else if (pend_q[B_LOAD])  sel_c[B_LOAD]  = 1'b1;

    legal_c = '0;
    case (fsm_state)
      ST_IDLE:  legal_c = 5'b00001;
      ST_RUN:   legal_c = 5'b11110;
      ST_LAP:   legal_c = 5'b01101;
      ST_STOP:  legal_c = 5'b01011;
      ST_CLEAR: legal_c = 5'b00111;
      default:  legal_c = 5'b00000;
    endcase

    issue_c  = sel_c & legal_c;
    n_pend_c = '0;
    for (int i = 0; i < int'(NB); i++) begin
      n_pend_c = n_pend_c + CNT_W'(pend_q[i]);
    end
    n_drop_c = n_pend_c - CNT_W'(|issue_c);
  end

  // Prescaler, command issue, pending update and drop accounting
  always_comb begin
    pre_last_c = (32'(pre_cnt_q) == DIV - 32'd1);
    pre_cnt_d  = pre_last_c ? '0 : pre_cnt_q + PRE_W'(1);
    tick_d     = pre_last_c;
    cmd_d      = '0;
    cmd_drop_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
    drop_sum_c = 9'(drop_cnt_q) + 9'(n_drop_c);
    pend_d     = pend_q | rise_c;
    if (tick_d) begin
      cmd_d      = issue_c;
      cmd_drop_d = (n_drop_c != '0);
      drop_cnt_d = drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
      // A press arriving on the clearing edge survives to the next tick
      pend_d     = rise_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_lvl_q   <= '0;
      db_prev_q  <= '0;
      pend_q     <= '0;
      pre_cnt_q  <= '0;
      tick_q     <= 1'b0;
      cmd_q      <= '0;
      cmd_drop_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < int'(NB); i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_lvl_q   <= db_lvl_d;
      db_prev_q  <= db_prev_d;
      pend_q     <= pend_d;
      pre_cnt_q  <= pre_cnt_d;
      tick_q     <= tick_d;
      cmd_q      <= cmd_d;
      cmd_drop_q <= cmd_drop_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < int'(NB); i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign tick     = tick_q;
  assign start    = cmd_q[B_START];
  assign lap      = cmd_q[B_LAP];
  assign stop     = cmd_q[B_STOP];
  assign clr      = cmd_q[B_CLR];
  assign load     = cmd_q[B_LOAD];
  assign cmd_drop = cmd_drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sw_cmd_sched.sv
// Scoreboard bench for sw_cmd_sched: expected commands/drops are queued when
// buttons are driven and popped when the scheduler issues at a tick.
module tb_sw_cmd_sched;

  localparam int unsigned DIV       = 4;
  localparam int unsigned DB_CYCLES = 3;
  localparam int          LAT_MAX   = int'(DB_CYCLES) + 2 + int'(DIV) + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_start = 1'b0, btn_lap = 1'b0, btn_stop = 1'b0;
  logic       btn_clr = 1'b0, btn_load = 1'b0;
  logic [2:0] fsm_state = 3'd0;
  logic       tick, start, lap, stop, clr, load, cmd_drop;
  logic [7:0] drop_cnt;

  sw_cmd_sched #(.DIV(DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_stop(btn_stop),
    .btn_clr(btn_clr), .btn_load(btn_load),
    .fsm_state(fsm_state),
    .tick(tick), .start(start), .lap(lap), .stop(stop), .clr(clr),
    .load(load), .cmd_drop(cmd_drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;   // 0 none, 1 start, 2 lap, 3 stop, 4 clr, 5 load
    int ndrop;
  } exp_t;

  exp_t exp_q[$];
  int   exp_drop = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [4:0] m);
    btn_start = m[0]; btn_lap = m[1]; btn_stop = m[2]; btn_clr = m[3]; btn_load = m[4];
  endtask

  function automatic int obs_code();
    case ({load, clr, stop, lap, start})
      5'b00000: return 0;
      5'b00001: return 1;
      5'b00010: return 2;
      5'b00100: return 3;
      5'b01000: return 4;
      5'b10000: return 5;
      default:  return -1;
    endcase
  endfunction

  function automatic bit legal(input int c, input int st);
    case (c)
      1:       return st inside {0, 2, 3, 4};
      2:       return st inside {1, 3, 4};
      3:       return st inside {1, 2, 4};
      4:       return st inside {1, 2, 3};
      5:       return st == 1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: one tick's outcome for a set of simultaneous presses
  function automatic void expect_press(input logic [4:0] m, input int st);
    exp_t e;
    int   order [5];
    int   sel;
    order = '{4, 3, 2, 1, 5};
    sel = 0;
    if (m == 5'b0) return;
    for (int k = 0; k < 5; k++) if (sel == 0 && m[order[k]-1]) sel = order[k];
    if (legal(sel, st)) begin
      e.code = sel; e.ndrop = $countones(m) - 1;
    end else begin
      e.code = 0;   e.ndrop = $countones(m);
    end
    exp_q.push_back(e);
  endfunction

  // Advance n cycles, popping the scoreboard whenever the DUT issues or drops
  task automatic watch(input int n, output int events, output int first);
    int   code;
    exp_t e;
    events = 0;
    first  = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      code = obs_code();
      n_cmp++;
      if (code < 0 || (!tick && (code != 0 || cmd_drop))) begin
        n_err++;
        $display("FAIL cmd_gate: tick=%0b cmds(ld,cl,sp,lp,st)=%b cmd_drop=%0b, required one-hot and only with tick",
                 tick, {load, clr, stop, lap, start}, cmd_drop);
      end
      if (tick && (code != 0 || cmd_drop)) begin
        events++;
        if (first < 0) first = i;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_issue: cmd=%0d cmd_drop=%0b, required nothing", code, cmd_drop);
        end else begin
          e = exp_q.pop_front();
          if (code !== e.code || cmd_drop !== (e.ndrop != 0)) begin
            n_err++;
            $display("FAIL issue: cmd=%0d cmd_drop=%0b, required cmd=%0d cmd_drop=%0b",
                     code, cmd_drop, e.code, e.ndrop != 0);
          end
          exp_drop = (exp_drop + e.ndrop > 255) ? 255 : exp_drop + e.ndrop;
        end
      end
      n_cmp++;
      if (drop_cnt !== 8'(exp_drop)) begin
        n_err++;
        $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, exp_drop);
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing: %0d expected issues never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if ({tick, start, lap, stop, clr, load, cmd_drop, drop_cnt} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required all zero", {tick, start, lap, stop, clr, load, cmd_drop, drop_cnt});
    end
    rst_n = 1'b1;
    exp_drop = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_cmp++;
      if (tick !== ((c % int'(DIV)) == 0) || obs_code() !== 0 || cmd_drop !== 1'b0 || drop_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL reset_tick c=%0d: tick=%0b cmd=%0d drop=%0b cnt=%0d, required tick=%0b and rest 0",
                 c, tick, obs_code(), cmd_drop, drop_cnt, (c % int'(DIV)) == 0);
      end
    end
  endtask

  task automatic test_glitch();
    int ev, f, total;
    fsm_state = 3'd0;
    total = 0;
    set_btn(5'b00001); watch(1, ev, f); total += ev;
    set_btn(5'b00000); watch(15, ev, f); total += ev;
    // Two cycles is still one short of the debounce window
    set_btn(5'b00001); watch(2, ev, f); total += ev;
    set_btn(5'b00000); watch(15, ev, f); total += ev;
    n_cmp++;
    if (total != 0) begin
      n_err++;
      $display("FAIL glitch: %0d issues, required 0", total);
    end
  endtask

  task automatic test_db_boundary();
    int ev1, ev2, f;
    fsm_state = 3'd0;
    expect_press(5'b00001, 0);
    set_btn(5'b00001); watch(int'(DB_CYCLES), ev1, f);
    set_btn(5'b00000); watch(17, ev2, f);
    n_cmp++;
    if (ev1 + ev2 != 1) begin
      n_err++;
      $display("FAIL db_boundary: %0d issues, required 1", ev1 + ev2);
    end
    check_drained("db_boundary");
  endtask

  task automatic test_start_hold();
    int ev1, ev2, first, f;
    fsm_state = 3'd0;
    expect_press(5'b00001, 0);
    set_btn(5'b00001); watch(20, ev1, first);
    set_btn(5'b00000); watch(12, ev2, f);
    n_cmp++;
    if (ev1 != 1 || ev2 != 0) begin
      n_err++;
      $display("FAIL start_hold_count: %0d+%0d issues, required 1+0", ev1, ev2);
    end
    n_cmp++;
    if (first < 1 || first > LAT_MAX) begin
      n_err++;
      $display("FAIL start_hold_latency: %0d cycles, required 1..%0d", first, LAT_MAX);
    end
    check_drained("start_hold");
  endtask

  task automatic test_priority();
    logic [4:0] masks [7];
    int         sts   [7];
    int         ev1, ev2, f;
    masks = '{5'b01010, 5'b01110, 5'b00101, 5'b10000, 5'b10001, 5'b11111, 5'b00010};
    sts   = '{1,        3,        0,        1,        0,        5,        4};
    for (int t = 0; t < 7; t++) begin
      fsm_state = 3'(sts[t]);
      expect_press(masks[t], sts[t]);
      set_btn(masks[t]); watch(6, ev1, f);
      set_btn(5'b00000); watch(14, ev2, f);
      n_cmp++;
      if (ev1 + ev2 != 1) begin
        n_err++;
        $display("FAIL priority[%0d]: %0d issues, required 1", t, ev1 + ev2);
      end
      check_drained("priority");
    end
  endtask

  task automatic test_saturation();
    int ev, f;
    fsm_state = 3'd0;
    for (int p = 0; p < 300; p++) begin
      expect_press(5'b00100, 0);
      set_btn(5'b00100); watch(6, ev, f);
      set_btn(5'b00000); watch(8, ev, f);
    end
    check_drained("saturation");
    n_cmp++;
    if (drop_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL drop_saturate: got %0d, required 255", drop_cnt);
    end
  endtask

  task automatic test_hold_through_reset();
    int ev1, ev2, f;
    fsm_state = 3'd0;
    set_btn(5'b00001);
    rst_n = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    step();
    rst_n = 1'b1;
    expect_press(5'b00001, 0);
    watch(20, ev1, f);
    set_btn(5'b00000); watch(12, ev2, f);
    n_cmp++;
    if (ev1 + ev2 != 1) begin
      n_err++;
      $display("FAIL hold_through_reset: %0d issues, required 1", ev1 + ev2);
    end
    check_drained("hold_through_reset");
  endtask

  task automatic test_reset_pending();
    int ev, f, budget;
    fsm_state = 3'd0;
    budget = 0;
    while (tick !== 1'b1 && budget < 2 * int'(DIV)) begin
      step();
      budget++;
    end
    n_cmp++;
    if (tick !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pending_sync: no tick within %0d cycles, required one", budget);
    end
    // Pending is set six edges after this tick; the next tick is two edges later
    set_btn(5'b00001); watch(5, ev, f);
    set_btn(5'b00000); watch(1, ev, f);
    rst_n = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    step();
    n_cmp++;
    if ({tick, start, lap, stop, clr, load, cmd_drop, drop_cnt} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_pending_outputs: got %b, required all zero", {tick, start, lap, stop, clr, load, cmd_drop, drop_cnt});
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_cmp++;
      if (tick !== ((c % int'(DIV)) == 0) || obs_code() !== 0 || cmd_drop !== 1'b0) begin
        n_err++;
        $display("FAIL reset_pending c=%0d: tick=%0b cmd=%0d drop=%0b, required tick=%0b no issue",
                 c, tick, obs_code(), cmd_drop, (c % int'(DIV)) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_db_boundary();
    test_start_hold();
    test_priority();
    test_saturation();
    test_hold_through_reset();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
